// File: rtl/fp_sched_pkg.sv
// rtl/fp_sched_pkg.sv - shared saturating fixed-point add helpers and stage payload type
package fp_sched_pkg;

  // Widest operand the helpers support; callers pass their real width w <= W_MAX.
  localparam int W_MAX  = 32;
  // Widest requester id (up to 16 requesters).
  localparam int ID_MAX = 4;

  typedef struct packed {
    logic [W_MAX-1:0]  a;
    logic [W_MAX-1:0]  b;
    logic              sgn;
    logic [ID_MAX-1:0] id;
  } stage_payload_t;

  // Largest positive two's complement value of a w-bit word.
  function automatic logic [W_MAX-1:0] sat_pos_max(input int w);
    logic [W_MAX:0] v;
    v = ((W_MAX+1)'(1) << (w - 1)) - (W_MAX+1)'(1);
    return v[W_MAX-1:0];
  endfunction

  // Most negative two's complement value of a w-bit word.
  function automatic logic [W_MAX-1:0] sat_neg_min(input int w);
    logic [W_MAX:0] v;
    v = (W_MAX+1)'(1) << (w - 1);
    return v[W_MAX-1:0];
  endfunction

  // All ones in the low w bits.
  function automatic logic [W_MAX-1:0] sat_uns_max(input int w);
    logic [W_MAX:0] v;
    v = ((W_MAX+1)'(1) << w) - (W_MAX+1)'(1);
    return v[W_MAX-1:0];
  endfunction

  // Saturating w-bit add; returns {ovf, result} with result in the low w bits.
  function automatic logic [W_MAX:0] sat_add(input logic [W_MAX-1:0] a,
                                             input logic [W_MAX-1:0] b,
                                             input logic             signed_mode,
                                             input int               w);
    logic [W_MAX:0]   ax;
    logic [W_MAX:0]   bx;
    logic [W_MAX:0]   sum;
    logic             a_ext;
    logic             b_ext;
    logic             ovf;
    logic [W_MAX-1:0] res;
    a_ext = signed_mode & a[w-1];
    b_ext = signed_mode & b[w-1];
    ax = '0;
    bx = '0;
    for (int i = 0; i < W_MAX; i++) begin
      ax[i] = (i < w) ? a[i] : a_ext;
      bx[i] = (i < w) ? b[i] : b_ext;
    end
    ax[W_MAX] = a_ext;
    bx[W_MAX] = b_ext;
    sum = ax + bx;
    if (signed_mode) begin
      ovf = (sum[w] != sum[w-1]);
      res = sum[w] ? sat_neg_min(w) : sat_pos_max(w);
    end else begin
      ovf = sum[w];
      res = sat_uns_max(w);
    end
    if (!ovf) begin
      res = sum[W_MAX-1:0] & sat_uns_max(w);
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter holding the last-granted pointer
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           advance,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] last_q;
  logic [IDW-1:0] last_d;
  logic           found;
  int             idx;

  // Search last+1, last+2, ... (mod N) and pick the first pending requester.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    idx      = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_q) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        grant_id = IDW'(idx);
      end
    end
  end

  // Grant only when the pipeline can take the request; pointer moves on a transfer.
  always_comb begin
    grant  = '0;
    last_d = last_q;
    if (found && advance) begin
      grant[grant_id] = 1'b1;
      last_d          = grant_id;
    end
  end

  // Pointer register; reset makes requester 0 the first candidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fp_add_sched.sv
// rtl/fp_add_sched.sv - round-robin time-shared saturating fixed-point adder
module fp_add_sched
  import fp_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int I     = 2,
  parameter  int F     = 14,
  parameter  int CNT_W = 16,
  localparam int W     = I + F,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_signed,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_ovf,
  output logic [CNT_W-1:0]   ovf_count
);

  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_id;
  logic             s1_adv;
  logic             s2_adv;
  logic [W_MAX:0]   add_res;

  logic             s1_valid_q, s1_valid_d;
  stage_payload_t   s1_q, s1_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  // Stage 2 moves when empty or drained; stage 1 moves when empty or stage 2 moves.
  // Reset blocks grants so nothing is accepted while rst is high.
  assign s2_adv = !rsp_valid_q || rsp_ready;
  assign s1_adv = (!s1_valid_q || s2_adv) && !rst;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .advance  (s1_adv),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;

  // Stage 1: capture the granted request's operands, mode and id.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv) begin
      s1_valid_d = |grant;
      if (|grant) begin
        s1_d.a   = W_MAX'(req_a[int'(grant_id)*W +: W]);
        s1_d.b   = W_MAX'(req_b[int'(grant_id)*W +: W]);
        s1_d.sgn = req_signed[grant_id];
        s1_d.id  = ID_MAX'(grant_id);
      end
    end
  end

  // The shared adder sits between the two stages.
  always_comb begin
    add_res = sat_add(s1_q.a, s1_q.b, s1_q.sgn, W);
  end

  // Stage 2: register the saturated sum; hold everything under backpressure.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_ovf_d   = rsp_ovf_q;
    if (s2_adv) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_data_d = add_res[W-1:0];
        rsp_ovf_d  = add_res[W_MAX];
        rsp_id_d   = s1_q.id[IDW-1:0];
      end
    end
  end

  // Count delivered overflowing results, sticking at all ones.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (rsp_valid_q && rsp_ready && rsp_ovf_q && (ovf_count_q != '1)) begin
      ovf_count_d = ovf_count_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_ovf_q   <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ovf_q   <= rsp_ovf_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_fp_add_sched.sv
// tb/tb_fp_add_sched.sv - randomized self-checking bench for fp_add_sched
module tb_fp_add_sched;

  localparam int N       = 4;
  localparam int I       = 2;
  localparam int F       = 14;
  localparam int W       = I + F;
  localparam int CNT_W   = 4;
  localparam int IDW     = $clog2(N);
  localparam longint FULL    = 64'(1) << W;
  localparam longint HALF    = FULL / 2;
  localparam longint OVF_MAX = (64'(1) << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_a;
  logic [N*W-1:0]     req_b;
  logic [N-1:0]       req_signed;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [W-1:0]       rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_ovf;
  logic [CNT_W-1:0]   ovf_count;

  fp_add_sched #(.N_REQ(N), .I(I), .F(F), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ovf    (rsp_ovf),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [W-1:0] data;
    logic       ovf;
    int         t;
  } exp_t;

  exp_t         q[$];
  logic [N-1:0] pend;
  logic [W-1:0] ra[N];
  logic [W-1:0] rb[N];
  logic         rs[N];
  int           mlast;
  longint       m_ovf;
  int           ecnt;
  int           n_grants;
  int           n_cmp;
  int           n_bad;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Arithmetic reference: exact sum, clamped to the representable range.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint va, vb, sum, lo, hi;
    logic ovf;
    va = longint'(a);
    vb = longint'(b);
    if (s) begin
      if (a[W-1]) va = va - FULL;
      if (b[W-1]) vb = vb - FULL;
      lo = -HALF;
      hi = HALF - 1;
    end else begin
      lo = 0;
      hi = FULL - 1;
    end
    sum = va + vb;
    ovf = 1'b0;
    if (sum > hi) begin
      sum = hi;
      ovf = 1'b1;
    end else if (sum < lo) begin
      sum = lo;
      ovf = 1'b1;
    end
    return {ovf, W'(sum)};
  endfunction

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    pend[k] = 1'b1;
    ra[k]   = a;
    rb[k]   = b;
    rs[k]   = s;
  endtask

  // One clock: drive, check against the model, then advance the model over the edge.
  task automatic cycle(input int p_new, input logic rdy, input logic [N-1:0] mask, input int sgn_mode);
    int           exp_id;
    logic [N-1:0] exp_gnt;
    logic         exp_v;
    logic [W:0]   r;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (!pend[k] && mask[k] && (int'($urandom_range(99)) < p_new)) begin
        pend[k] = 1'b1;
        ra[k]   = W'($urandom);
        rb[k]   = W'($urandom);
        rs[k]   = (sgn_mode == 2) ? 1'($urandom_range(1)) : 1'(sgn_mode);
      end
    end
    req_valid = pend;
    for (int k = 0; k < N; k++) begin
      req_a[k*W +: W] = ra[k];
      req_b[k*W +: W] = rb[k];
      req_signed[k]   = rs[k];
    end
    rsp_ready = rdy;
    #1;
    exp_id = -1;
    if (q.size() < 2 || rdy) begin
      for (int i = 1; i <= N; i++) begin
        if (exp_id < 0 && pend[(mlast + i) % N]) exp_id = (mlast + i) % N;
      end
    end
    exp_gnt = '0;
    if (exp_id >= 0) exp_gnt[exp_id] = 1'b1;
    check_eq("grant", longint'(req_ready), longint'(exp_gnt));
    if (|req_ready) n_grants++;
    exp_v = (q.size() > 0) && (ecnt >= q[0].t + 1);
    check_eq("rsp_valid", longint'(rsp_valid), longint'(exp_v));
    if (exp_v && rsp_valid) begin
      check_eq("rsp_data", longint'(rsp_data), longint'(q[0].data));
      check_eq("rsp_id", longint'(rsp_id), longint'(q[0].id));
      check_eq("rsp_ovf", longint'(rsp_ovf), longint'(q[0].ovf));
    end
    check_eq("ovf_count", longint'(ovf_count), m_ovf);
    if (exp_v && rdy) begin
      if (q[0].ovf && m_ovf < OVF_MAX) m_ovf++;
      void'(q.pop_front());
    end
    if (exp_id >= 0) begin
      r = ref_add(ra[exp_id], rb[exp_id], rs[exp_id]);
      q.push_back('{exp_id, r[W-1:0], r[W], ecnt + 1});
      pend[exp_id] = 1'b0;
      mlast = exp_id;
    end
    @(posedge clk);
    ecnt++;
  endtask

  task automatic run(input int n, input int p_new, input int rdy_pct, input logic [N-1:0] mask, input int sgn_mode);
    for (int c = 0; c < n; c++) begin
      cycle(p_new, 1'(int'($urandom_range(99)) < rdy_pct), mask, sgn_mode);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; ecnt = 0; n_grants = 0;
    mlast = N - 1; m_ovf = 0; pend = '0;
    for (int k = 0; k < N; k++) begin
      ra[k] = '0; rb[k] = '0; rs[k] = 1'b0;
    end
    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; req_signed = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", longint'(req_ready), 0);
    check_eq("rst_rsp_valid", longint'(rsp_valid), 0);
    check_eq("rst_rsp_data", longint'(rsp_data), 0);
    check_eq("rst_rsp_id", longint'(rsp_id), 0);
    check_eq("rst_rsp_ovf", longint'(rsp_ovf), 0);
    check_eq("rst_ovf_count", longint'(ovf_count), 0);
    req_valid = '0;
    #1 rst = 1'b0;

    set_req(0, 16'h6000, 16'h6000, 1'b0);
    run(4, 0, 100, '1, 0);
    set_req(0, 16'hC000, 16'h8000, 1'b0);
    run(4, 0, 100, '1, 0);
    set_req(1, 16'h6000, 16'h4000, 1'b1);
    set_req(2, 16'h8000, 16'hE000, 1'b1);
    set_req(3, 16'h2000, 16'hF000, 1'b1);
    run(6, 0, 100, '1, 0);

    run(12, 100, 100, 4'b1111, 2);
    run(12, 100, 100, 4'b1011, 2);
    run(4, 0, 100, '0, 2);

    n_grants = 0;
    run(5, 100, 0, 4'b1111, 2);
    check_eq("bp_accepted", longint'(n_grants), 2);
    run(8, 100, 100, 4'b1111, 2);
    run(4, 0, 100, '0, 2);

    run(10, 100, 100, 4'b0001, 1);
    run(4, 0, 100, '0, 2);

    run(600, 60, 70, '1, 2);
    run(6, 0, 100, '0, 2);

    run(3, 100, 0, 4'b1111, 2);
    pend[0] = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_rsp_valid", longint'(rsp_valid), 0);
    check_eq("arst_ovf_count", longint'(ovf_count), 0);
    check_eq("arst_req_ready", longint'(req_ready), 0);
    q.delete();
    mlast = N - 1;
    m_ovf = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("post_rst_first", longint'(req_ready), 1);
    run(40, 60, 70, '1, 2);
    run(6, 0, 100, '0, 2);
    check_eq("final_queue_empty", longint'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
